// File: rtl/memory_hw_pkg.sv
// Shared constants for the two-slot write-once memory with FND readout.
// Optional build macro: FND_DASH_EN (invalid slots show a dash after a read).
package memory_hw_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;

    localparam logic [6:0] FND_BLANK = 7'h7F;
    localparam logic [6:0] FND_DASH  = 7'h3F;

    // Active-low segments, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/memory_hw_if.sv
// Bus bundle between the memory and its user: write/read strobes in, status and
// display out.
//
// Handshake: din_vld and read are single-cycle strobes sampled on every rising
// edge; there is no ready. A write is accepted only when full is low at that
// edge, otherwise it is silently dropped. dout_vld is high for the cycle after
// each sampled read, when the fnd_out* registers hold the fresh snapshot.
interface memory_hw_if;
    import memory_hw_pkg::*;

    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              read;
    logic              full;
    logic [DEPTH-1:0]  status_vld;
    logic              dout_vld;
    logic [6:0]        fnd_out1;
    logic [6:0]        fnd_out2;
    logic [6:0]        fnd_out3;
    logic [6:0]        fnd_out4;

    modport master (
        output din, din_vld, read,
        input  full, status_vld, dout_vld, fnd_out1, fnd_out2, fnd_out3, fnd_out4
    );

    modport slave (
        input  din, din_vld, read,
        output full, status_vld, dout_vld, fnd_out1, fnd_out2, fnd_out3, fnd_out4
    );

endinterface

// File: rtl/memory_hw_fnd_hex_dec.sv
// Combinational nibble to active-low 7-segment decoder.
module fnd_hex_dec
    import memory_hw_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Straight table lookup; every nibble value has a code.
    always_comb begin
        seg = HEX_SEG[nib];
    end

endmodule

// File: rtl/memory_hw.sv
// Two-slot, 8-bit write-once memory with a 4-digit FND snapshot on read.
// Optional build macro: FND_DASH_EN (invalid-slot digits read back as a dash
// instead of blank; reset still blanks the display).
module memory_hw
    import memory_hw_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    memory_hw_if.slave  bus
);

`ifdef FND_DASH_EN
    localparam logic [6:0] FND_INVALID = FND_DASH;
`else
    localparam logic [6:0] FND_INVALID = FND_BLANK;
`endif

    logic [DATA_W-1:0] slot0_q, slot0_d;
    logic [DATA_W-1:0] slot1_q, slot1_d;
    logic [DEPTH-1:0]  status_q, status_d;
    logic              dout_vld_q, dout_vld_d;
    logic [6:0]        fnd1_q, fnd1_d;
    logic [6:0]        fnd2_q, fnd2_d;
    logic [6:0]        fnd3_q, fnd3_d;
    logic [6:0]        fnd4_q, fnd4_d;
    logic [6:0]        seg1, seg2, seg3, seg4;
    logic              full;

    assign full = &status_q;

    // Decoders look at the stored (pre-edge) slot contents, so a same-cycle
    // write never shows up in the snapshot taken by a concurrent read.
    fnd_hex_dec u_dec1 (.nib(slot0_q[7:4]), .seg(seg1));
    fnd_hex_dec u_dec2 (.nib(slot0_q[3:0]), .seg(seg2));
    fnd_hex_dec u_dec3 (.nib(slot1_q[7:4]), .seg(seg3));
    fnd_hex_dec u_dec4 (.nib(slot1_q[3:0]), .seg(seg4));

    // Next-state: fill lowest empty slot on write, snapshot display on read.
    always_comb begin
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        status_d   = status_q;
        fnd1_d     = fnd1_q;
        fnd2_d     = fnd2_q;
        fnd3_d     = fnd3_q;
        fnd4_d     = fnd4_q;
        dout_vld_d = bus.read;

        if (bus.din_vld && !full) begin
            if (!status_q[0]) begin
                slot0_d  = bus.din;
                status_d = 2'b01;
            end else begin
                slot1_d  = bus.din;
                status_d = 2'b11;
            end
        end

        if (bus.read) begin
            fnd1_d = status_q[0] ? seg1 : FND_INVALID;
            fnd2_d = status_q[0] ? seg2 : FND_INVALID;
            fnd3_d = status_q[1] ? seg3 : FND_INVALID;
            fnd4_d = status_q[1] ? seg4 : FND_INVALID;
        end
    end

    // State registers; reset empties the memory and blanks the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q    <= '0;
            slot1_q    <= '0;
            status_q   <= '0;
            dout_vld_q <= 1'b0;
            fnd1_q     <= FND_BLANK;
            fnd2_q     <= FND_BLANK;
            fnd3_q     <= FND_BLANK;
            fnd4_q     <= FND_BLANK;
        end else begin
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            status_q   <= status_d;
            dout_vld_q <= dout_vld_d;
            fnd1_q     <= fnd1_d;
            fnd2_q     <= fnd2_d;
            fnd3_q     <= fnd3_d;
            fnd4_q     <= fnd4_d;
        end
    end

    assign bus.full       = full;
    assign bus.status_vld = status_q;
    assign bus.dout_vld   = dout_vld_q;
    assign bus.fnd_out1   = fnd1_q;
    assign bus.fnd_out2   = fnd2_q;
    assign bus.fnd_out3   = fnd3_q;
    assign bus.fnd_out4   = fnd4_q;

endmodule

// File: tb/tb_memory_hw.sv
// Directed bench for memory_hw: reset, fill, drop-on-full, read snapshots,
// same-cycle write+read, held strobes and reset while full.
module tb_memory_hw;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [6:0] exp_q[$];
    logic [6:0] exp_inv;

    memory_hw_if bus ();

    memory_hw dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drivers: inputs change 1ns after the edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din     = '0;
        bus.din_vld = 1'b0;
        bus.read    = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] data);
        bus.din     = data;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
    endtask

    task automatic do_read();
        bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
    endtask

    // Scoreboard: queue the four expected digits, then compare in order.
    task automatic expect_fnd(input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3, input logic [6:0] e4);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
        exp_q.push_back(e4);
    endtask

    task automatic check_fnd(input string tag);
        logic [6:0] e;
        e = exp_q.pop_front(); check({tag, ".fnd1"}, 32'(bus.fnd_out1), 32'(e));
        e = exp_q.pop_front(); check({tag, ".fnd2"}, 32'(bus.fnd_out2), 32'(e));
        e = exp_q.pop_front(); check({tag, ".fnd3"}, 32'(bus.fnd_out3), 32'(e));
        e = exp_q.pop_front(); check({tag, ".fnd4"}, 32'(bus.fnd_out4), 32'(e));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef FND_DASH_EN
        exp_inv = 7'h3F;
`else
        exp_inv = 7'h7F;
`endif
        rst = 1'b1;
        idle_inputs();

        // Reset state
        do_reset(2);
        check("rst.status", 32'(bus.status_vld), 32'h0);
        check("rst.full", 32'(bus.full), 32'h0);
        check("rst.dout_vld", 32'(bus.dout_vld), 32'h0);
        expect_fnd(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check_fnd("rst");

        // Write 0x89, read two cycles later
        do_write(8'h89);
        check("w1.status", 32'(bus.status_vld), 32'h1);
        check("w1.full", 32'(bus.full), 32'h0);
        tick();
        do_read();
        check("r1.dout_vld", 32'(bus.dout_vld), 32'h1);
        expect_fnd(7'h00, 7'h10, exp_inv, exp_inv);
        check_fnd("r1");
        tick();
        check("r1.dout_pulse", 32'(bus.dout_vld), 32'h0);

        // Write 0xFE fills memory
        do_write(8'hFE);
        check("w2.status", 32'(bus.status_vld), 32'h3);
        check("w2.full", 32'(bus.full), 32'h1);
        do_read();
        check("r2.dout_vld", 32'(bus.dout_vld), 32'h1);
        expect_fnd(7'h00, 7'h10, 7'h0E, 7'h06);
        check_fnd("r2");

        // Write while full is dropped
        do_write(8'h98);
        check("w3.status", 32'(bus.status_vld), 32'h3);
        check("w3.dout_vld", 32'(bus.dout_vld), 32'h0);
        do_read();
        check("r3.dout_vld", 32'(bus.dout_vld), 32'h1);
        expect_fnd(7'h00, 7'h10, 7'h0E, 7'h06);
        check_fnd("r3");

        // Held read keeps dout_vld high
        bus.read = 1'b1;
        tick();
        check("hr.dout_vld0", 32'(bus.dout_vld), 32'h1);
        tick();
        check("hr.dout_vld1", 32'(bus.dout_vld), 32'h1);
        bus.read = 1'b0;
        tick();
        check("hr.dout_end", 32'(bus.dout_vld), 32'h0);

        // Reset while full with display loaded
        do_reset(1);
        check("rf.status", 32'(bus.status_vld), 32'h0);
        check("rf.full", 32'(bus.full), 32'h0);
        check("rf.dout_vld", 32'(bus.dout_vld), 32'h0);
        expect_fnd(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check_fnd("rf");

        // Same-cycle write and read from empty: display shows pre-write state
        bus.din     = 8'h89;
        bus.din_vld = 1'b1;
        bus.read    = 1'b1;
        tick();
        idle_inputs();
        check("wr.status", 32'(bus.status_vld), 32'h1);
        check("wr.dout_vld", 32'(bus.dout_vld), 32'h1);
        expect_fnd(exp_inv, exp_inv, exp_inv, exp_inv);
        check_fnd("wr");

        // Held din_vld for two cycles from empty fills both slots
        do_reset(1);
        bus.din_vld = 1'b1;
        bus.din     = 8'hA5;
        tick();
        check("hw.status0", 32'(bus.status_vld), 32'h1);
        bus.din     = 8'h3C;
        tick();
        bus.din_vld = 1'b0;
        check("hw.status1", 32'(bus.status_vld), 32'h3);
        check("hw.full", 32'(bus.full), 32'h1);
        do_read();
        expect_fnd(7'h08, 7'h12, 7'h30, 7'h46);
        check_fnd("hw");

        // More decode coverage: 0x07 then 0xBD
        do_reset(1);
        do_write(8'h07);
        do_write(8'hBD);
        do_read();
        expect_fnd(7'h40, 7'h78, 7'h03, 7'h21);
        check_fnd("dc");

        // Remaining nibbles: 0x16 then 0x24
        do_reset(1);
        do_write(8'h16);
        do_write(8'h24);
        do_read();
        expect_fnd(7'h79, 7'h02, 7'h24, 7'h19);
        check_fnd("dc2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
